// File: rtl/pong_video_renderer.sv
// Purpose : VGA raster generator and pixel renderer for the pong game state.
// Latency : one pix_en step from hcount/vcount to hsync/vsync/video_on/rgb.
// Backpr. : none; pix_en low freezes every counter and register.
//
// Ports: clk/rst_n (sync active-low), pix_en pixel-rate enable,
//        x_/y_ paddle and ball corners, scrA/scrB scores, lossA/lossB flags,
//        hsync/vsync (active low), rgb {R,G,B}, video_on, frame_tick,
//        hcount/vcount raster counters.
module pong_video_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PAD_W    = 8,
  parameter int PAD_H    = 64,
  parameter int BALL_W   = 8,
  parameter int BALL_H   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] x_padA,
  input  logic [9:0] y_padA,
  input  logic [9:0] x_padB,
  input  logic [9:0] y_padB,
  input  logic [9:0] x_ball,
  input  logic [9:0] y_ball,
  input  logic [2:0] scrA,
  input  logic [2:0] scrB,
  input  logic       lossA,
  input  logic       lossB,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       video_on,
  output logic       frame_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount
);

  // All raster arithmetic is done in 11 bits so object edges near 1023 clip
  // instead of wrapping back onto the left/top of the screen.
  localparam logic [10:0] H_TOT    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOT    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] HA       = 11'(H_ACTIVE);
  localparam logic [10:0] VA       = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] PW       = 11'(PAD_W);
  localparam logic [10:0] PH       = 11'(PAD_H);
  localparam logic [10:0] BW       = 11'(BALL_W);
  localparam logic [10:0] BH       = 11'(BALL_H);
  // Field geometry scales with the active width: 320 / 160 / 368 at 640.
  localparam logic [10:0] MID      = 11'(H_ACTIVE / 2);
  localparam logic [10:0] PIP_A_X  = 11'(H_ACTIVE / 4);
  localparam logic [10:0] PIP_B_X  = 11'(H_ACTIVE / 2 + 48);

  // Game state latched once per frame so objects never tear mid-frame.
  logic [9:0] x_pad_a_q, y_pad_a_q, x_pad_b_q, y_pad_b_q, x_ball_q, y_ball_q;
  logic [2:0] scr_a_q, scr_b_q;
  logic       loss_a_q, loss_b_q;

  logic [10:0] hc, vc, pa_off, pb_off;
  logic        last_h, last_v, active;
  logic        ball_hit, pad_a_hit, pad_b_hit, pip_row, pip_a, pip_b;
  logic        centre, bg_red;
  logic [2:0]  rgb_next;

  function automatic logic hit(input logic [9:0] ox, input logic [9:0] oy,
                               input logic [10:0] w, input logic [10:0] h,
                               input logic [10:0] px, input logic [10:0] py);
    logic [10:0] x0, y0;
    x0 = {1'b0, ox};
    y0 = {1'b0, oy};
    return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
  endfunction

  assign hc     = {1'b0, hcount};
  assign vc     = {1'b0, vcount};
  assign last_h = (hc == H_TOT - 11'd1);
  assign last_v = (vc == V_TOT - 11'd1);
  assign active = (hc < HA) && (vc < VA);

  assign frame_tick = rst_n && pix_en && (hc == HA - 11'd1) && (vc == VA - 11'd1);

  assign ball_hit  = hit(x_ball_q,  y_ball_q,  BW, BH, hc, vc);
  assign pad_a_hit = hit(x_pad_a_q, y_pad_a_q, PW, PH, hc, vc);
  assign pad_b_hit = hit(x_pad_b_q, y_pad_b_q, PW, PH, hc, vc);

  // Pips sit on a 16-px pitch: offset bit 3 clear selects the lit half,
  // offset bits 6:4 give the pip index compared against the score.
  assign pa_off  = hc - PIP_A_X;
  assign pb_off  = hc - PIP_B_X;
  assign pip_row = (vc >= 11'd8) && (vc < 11'd16);
  assign pip_a   = pip_row && (hc >= PIP_A_X) && (pa_off < 11'd128) &&
                   !pa_off[3] && (pa_off[6:4] < scr_a_q);
  assign pip_b   = pip_row && (hc >= PIP_B_X) && (pb_off < 11'd128) &&
                   !pb_off[3] && (pb_off[6:4] < scr_b_q);

  assign centre = ((hc == MID - 11'd1) || (hc == MID)) && !vc[4];
  assign bg_red = (loss_a_q && (hc < MID)) || (loss_b_q && (hc >= MID));

  always_comb begin
    rgb_next = 3'b000;
    if (!active)        rgb_next = 3'b000;
    else if (ball_hit)  rgb_next = 3'b111;
    else if (pad_a_hit) rgb_next = 3'b010;
    else if (pad_b_hit) rgb_next = 3'b001;
    else if (pip_a)     rgb_next = 3'b010;
    else if (pip_b)     rgb_next = 3'b001;
    else if (centre)    rgb_next = 3'b111;
    else if (bg_red)    rgb_next = 3'b100;
  end

  // Raster counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount   <= '0;
      vcount   <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      rgb      <= 3'b000;
    end else if (pix_en) begin
      if (last_h) begin
        hcount <= '0;
        vcount <= last_v ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
      hsync    <= !((hc >= HS_START) && (hc < HS_END));
      vsync    <= !((vc >= VS_START) && (vc < VS_END));
      video_on <= active;
      rgb      <= rgb_next;
    end
  end

  // Snapshot on the last pixel of the frame so the next frame sees it from (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_pad_a_q <= '0; y_pad_a_q <= '0;
      x_pad_b_q <= '0; y_pad_b_q <= '0;
      x_ball_q  <= '0; y_ball_q  <= '0;
      scr_a_q   <= '0; scr_b_q   <= '0;
      loss_a_q  <= 1'b0;
      loss_b_q  <= 1'b0;
    end else if (pix_en && last_h && last_v) begin
      x_pad_a_q <= x_padA; y_pad_a_q <= y_padA;
      x_pad_b_q <= x_padB; y_pad_b_q <= y_padB;
      x_ball_q  <= x_ball; y_ball_q  <= y_ball;
      scr_a_q   <= scrA;   scr_b_q   <= scrB;
      loss_a_q  <= lossA;
      loss_b_q  <= lossB;
    end
  end

endmodule
